// File: rtl/pc_fetch_ctrl.sv
// PC owner and instruction fetch sequencer: req/ack fetch, valid/ready issue, redirects.
// Optional MISALIGN_TRAP_EN sends misaligned redirect targets to TRAP_VECTOR.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch,
   input  logic        ALU_zero,
   input  logic        jump,
   input  logic [31:0] ex_pc,
   input  logic [63:0] imm_gen_out,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        flush,
   output logic [31:0] retire_cnt,
   output logic        misalign_trap
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_VALID
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic [31:0] instr_q;
   logic [31:0] ipc_q;
   logic [31:0] cnt_q;
   logic        drop_q;
   logic        req_q;
   logic        valid_q;
   logic        flush_q;
   logic        trap_q;

   logic        redir;
   logic        mis;
   logic [31:0] raw_tgt;
   logic [31:0] tgt_d;
   logic [31:0] pc_inc;
   logic        unused_ok;

   assign unused_ok = ^{imm_gen_out[63:31], TRAP_VECTOR};

   always_comb begin
      redir   = jump | (branch & ALU_zero);
      raw_tgt = jump ? jump_target
                     : ex_pc + {imm_gen_out[30:0], 1'b0};
      raw_tgt[0] = 1'b0;
      pc_inc  = pc_q + 32'd4;
`ifdef MISALIGN_TRAP_EN
      mis   = raw_tgt[1];
      tgt_d = mis ? TRAP_VECTOR : raw_tgt;
`else
      mis   = 1'b0;
      tgt_d = {raw_tgt[31:2], 2'b00};
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_VECTOR;
         addr_q  <= '0;
         instr_q <= '0;
         ipc_q   <= '0;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         flush_q <= 1'b0;
         trap_q  <= 1'b0;
      end else begin
         flush_q <= 1'b0;
         trap_q  <= 1'b0;
         if (state_q != S_BOOT && redir) begin
            flush_q <= 1'b1;
            trap_q  <= mis;
         end
         unique case (state_q)
            S_BOOT: begin
               state_q <= S_REQ;
               req_q   <= 1'b1;
               addr_q  <= pc_q;
            end
            S_REQ: begin
               if (redir) begin
                  pc_q   <= tgt_d;
                  addr_q <= tgt_d;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_ack) begin
                  drop_q <= 1'b0;
                  if (redir) begin
                     pc_q    <= tgt_d;
                     addr_q  <= tgt_d;
                     state_q <= S_REQ;
                  end else if (drop_q) begin
                     state_q <= S_REQ;
                  end else begin
                     instr_q <= imem_rdata;
                     ipc_q   <= pc_q;
                     valid_q <= 1'b1;
                     req_q   <= 1'b0;
                     state_q <= S_VALID;
                  end
               end else if (redir) begin
                  // response still in flight belongs to the old path
                  drop_q <= 1'b1;
                  pc_q   <= tgt_d;
                  addr_q <= tgt_d;
               end
            end
            S_VALID: begin
               if (instr_ready) begin
                  cnt_q <= cnt_q + 32'd1;
               end
               if (redir) begin
                  pc_q    <= tgt_d;
                  addr_q  <= tgt_d;
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
               end else if (instr_ready) begin
                  pc_q    <= pc_inc;
                  addr_q  <= pc_inc;
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
               end
            end
            default: state_q <= S_BOOT;
         endcase
      end
   end

   assign imem_req      = req_q;
   assign imem_addr     = addr_q;
   assign instr_valid   = valid_q;
   assign instr_out     = instr_q;
   assign instr_pc      = ipc_q;
   assign flush         = flush_q;
   assign retire_cnt    = cnt_q;
   assign misalign_trap = trap_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus a randomized run
// against a transaction-level model of fetch, issue and redirect.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        branch = 1'b0;
   logic        ALU_zero = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] ex_pc = '0;
   logic [63:0] imm_gen_out = '0;
   logic [31:0] jump_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        flush;
   logic [31:0] retire_cnt;
   logic        misalign_trap;

   int passed = 0;
   int total = 0;

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   pc_fetch_ctrl dut (
      .clk(clk), .reset(reset), .branch(branch), .ALU_zero(ALU_zero),
      .jump(jump), .ex_pc(ex_pc), .imm_gen_out(imm_gen_out),
      .jump_target(jump_target), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr_out(instr_out),
      .instr_pc(instr_pc), .flush(flush), .retire_cnt(retire_cnt),
      .misalign_trap(misalign_trap)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached passed=%0d total=%0d", passed, total);
      $fatal(1);
   end

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Waits (bounded) for a fetch, acks after dly cycles, returns at the
   // sample point one clock after the ack.
   task automatic fetch_once(input int dly, output logic [31:0] a,
                             output bit stable, output bit ok);
      ok = 1'b0;
      stable = 1'b1;
      a = '0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req === 1'b1) break;
         @(negedge clk);
      end
      if (imem_req !== 1'b1) return;
      a = imem_addr;
      repeat (dly) begin
         @(negedge clk);
         if (imem_addr !== a || imem_req !== 1'b1) stable = 1'b0;
      end
      imem_rdata = mem(imem_addr);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      ok = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else passed++;
      total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instr_valid); else passed++;
      total++; if (retire_cnt !== 32'd0) $display("FAIL reset_cnt got=%h exp=0", retire_cnt); else passed++;
      total++; if (imem_addr !== 32'd0 || flush !== 1'b0 || misalign_trap !== 1'b0)
         $display("FAIL reset_misc addr=%h flush=%b trap=%b exp all 0", imem_addr, flush, misalign_trap);
      else passed++;
      reset = 1'b1;
   endtask

   task automatic test_sequential();
      logic [31:0] a;
      bit st, ok;
      instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         fetch_once(1, a, st, ok);
         total++; if (!ok || a !== 32'(4 * k))
            $display("FAIL seq_addr k=%0d got=%h exp=%h ok=%b", k, a, 32'(4 * k), ok);
         else passed++;
         total++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr_out !== mem(32'(4 * k)))
            $display("FAIL seq_word k=%0d valid=%b pc=%h out=%h exp pc=%h out=%h",
                     k, instr_valid, instr_pc, instr_out, 32'(4 * k), mem(32'(4 * k)));
         else passed++;
      end
      @(negedge clk);
      total++; if (retire_cnt !== 32'd3) $display("FAIL seq_cnt got=%0d exp=3", retire_cnt); else passed++;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'd12)
         $display("FAIL seq_next req=%b addr=%h exp req=1 addr=0000000c", imem_req, imem_addr);
      else passed++;
   endtask

   task automatic test_delayed_ack();
      logic [31:0] a;
      bit st, ok;
      instr_ready = 1'b0;
      fetch_once(4, a, st, ok);
      total++; if (!ok || !st || a !== 32'd12)
         $display("FAIL dly_hold ok=%b stable=%b addr=%h exp 1 1 0000000c", ok, st, a);
      else passed++;
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'd12 || instr_out !== mem(32'd12))
         $display("FAIL dly_valid valid=%b pc=%h out=%h exp 1 0000000c %h", instr_valid, instr_pc, instr_out, mem(32'd12));
      else passed++;
      ex_pc = 32'h40;
      imm_gen_out = 64'h10;
      branch = 1'b1;
      ALU_zero = 1'b0;
      @(negedge clk);
      branch = 1'b0;
      total++; if (flush !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'd12)
         $display("FAIL not_taken flush=%b valid=%b pc=%h exp 0 1 0000000c", flush, instr_valid, instr_pc);
      else passed++;
      @(negedge clk);
      total++; if (instr_valid !== 1'b1 || retire_cnt !== 32'd3)
         $display("FAIL stall_hold valid=%b cnt=%0d exp 1 3", instr_valid, retire_cnt);
      else passed++;
      instr_ready = 1'b1;
      @(negedge clk);
      total++; if (instr_valid !== 1'b0 || retire_cnt !== 32'd4 || imem_req !== 1'b1 || imem_addr !== 32'd16)
         $display("FAIL dly_accept valid=%b cnt=%0d req=%b addr=%h exp 0 4 1 00000010",
                  instr_valid, retire_cnt, imem_req, imem_addr);
      else passed++;
   endtask

   task automatic test_branch();
      logic [31:0] a;
      bit st, ok;
      ex_pc = 32'h40;
      imm_gen_out = 64'h10;
      branch = 1'b1;
      ALU_zero = 1'b1;
      @(negedge clk);
      branch = 1'b0;
      ALU_zero = 1'b0;
      total++; if (flush !== 1'b1 || imem_addr !== 32'h60 || imem_req !== 1'b1)
         $display("FAIL br_redirect flush=%b addr=%h req=%b exp 1 00000060 1", flush, imem_addr, imem_req);
      else passed++;
      @(negedge clk);
      total++; if (flush !== 1'b0) $display("FAIL br_pulse got=%b exp=0", flush); else passed++;
      fetch_once(1, a, st, ok);
      total++; if (!ok || a !== 32'h60 || instr_valid !== 1'b1 || instr_pc !== 32'h60)
         $display("FAIL br_fetch ok=%b addr=%h valid=%b pc=%h exp 00000060", ok, a, instr_valid, instr_pc);
      else passed++;
   endtask

   task automatic test_redirect_wait();
      logic [31:0] a;
      bit st, ok;
      repeat (2) @(negedge clk);
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h64)
         $display("FAIL rw_pre req=%b addr=%h exp 1 00000064", imem_req, imem_addr);
      else passed++;
      jump = 1'b1;
      jump_target = 32'h200;
      @(negedge clk);
      jump = 1'b0;
      total++; if (flush !== 1'b1 || imem_addr !== 32'h200)
         $display("FAIL rw_flush flush=%b addr=%h exp 1 00000200", flush, imem_addr);
      else passed++;
      imem_rdata = mem(32'h64);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
         $display("FAIL rw_drop valid=%b req=%b addr=%h exp 0 1 00000200", instr_valid, imem_req, imem_addr);
      else passed++;
      fetch_once(1, a, st, ok);
      total++; if (!ok || a !== 32'h200 || instr_pc !== 32'h200 || retire_cnt !== 32'd5)
         $display("FAIL rw_fetch ok=%b addr=%h pc=%h cnt=%0d exp 00000200 00000200 5", ok, a, instr_pc, retire_cnt);
      else passed++;
   endtask

   task automatic test_jump_wrap();
      logic [31:0] a;
      bit st, ok;
      jump = 1'b1;
      jump_target = 32'hFFFF_FFFC;
      branch = 1'b1;
      ALU_zero = 1'b1;
      ex_pc = 32'h40;
      imm_gen_out = 64'h10;
      @(negedge clk);
      jump = 1'b0;
      branch = 1'b0;
      ALU_zero = 1'b0;
      total++; if (flush !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || retire_cnt !== 32'd6 || instr_valid !== 1'b0)
         $display("FAIL jw_prio flush=%b addr=%h cnt=%0d valid=%b exp 1 fffffffc 6 0",
                  flush, imem_addr, retire_cnt, instr_valid);
      else passed++;
      fetch_once(1, a, st, ok);
      total++; if (!ok || instr_pc !== 32'hFFFF_FFFC || instr_out !== mem(32'hFFFF_FFFC))
         $display("FAIL jw_fetch ok=%b pc=%h out=%h exp fffffffc %h", ok, instr_pc, instr_out, mem(32'hFFFF_FFFC));
      else passed++;
      @(negedge clk);
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || retire_cnt !== 32'd7)
         $display("FAIL jw_wrap req=%b addr=%h cnt=%0d exp 1 00000000 7", imem_req, imem_addr, retire_cnt);
      else passed++;
   endtask

   task automatic test_misalign();
      logic [31:0] a;
      bit st, ok;
      jump = 1'b1;
      jump_target = 32'h102;
      @(negedge clk);
      jump = 1'b0;
      total++; if (flush !== 1'b1 || imem_addr !== 32'h100 || misalign_trap !== TRAP)
         $display("FAIL mis_target flush=%b addr=%h trap=%b exp 1 00000100 %b", flush, imem_addr, misalign_trap, TRAP);
      else passed++;
      @(negedge clk);
      total++; if (misalign_trap !== 1'b0 || flush !== 1'b0)
         $display("FAIL mis_pulse trap=%b flush=%b exp 0 0", misalign_trap, flush);
      else passed++;
      fetch_once(1, a, st, ok);
      total++; if (!ok || a !== 32'h100 || instr_pc !== 32'h100)
         $display("FAIL mis_fetch ok=%b addr=%h pc=%h exp 00000100", ok, a, instr_pc);
      else passed++;
   endtask

   task automatic test_reset_midfetch();
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || retire_cnt !== 32'd0 || imem_addr !== 32'd0)
         $display("FAIL rst_async req=%b valid=%b cnt=%0d addr=%h exp all 0", imem_req, instr_valid, retire_cnt, imem_addr);
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      total++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'd0 || flush !== 1'b0)
         $display("FAIL rst_late_ack req=%b valid=%b addr=%h flush=%b exp 1 0 0 0", imem_req, instr_valid, imem_addr, flush);
      else passed++;
   endtask

   // Model: expected next fetch PC, retired count, and whether the DUT must
   // present a word this cycle (held word, or a clean ack last cycle).
   task automatic test_random(input int n);
      logic [31:0] exp_pc = '0;
      logic [31:0] exp_cnt = '0;
      logic [31:0] raw, t, jt, ex;
      logic [63:0] imm;
      logic pv = 1'b0, prdy = 1'b0, pred = 1'b0, pgood = 1'b0, ptrap = 1'b0;
      logic taint = 1'b0;
      logic ev, rd, jp, br, z, ack, redir, tr;
      int c = 0;
      int dly = 1;
      for (int i = 0; i < n; i++) begin
         ev = (pv && !prdy && !pred) || pgood;
         total++; if (instr_valid !== ev) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, instr_valid, ev); else passed++;
         total++; if (imem_req !== !ev) $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, imem_req, !ev); else passed++;
         total++; if (flush !== pred || misalign_trap !== ptrap)
            $display("FAIL rnd_flush cyc=%0d flush=%b trap=%b exp %b %b", i, flush, misalign_trap, pred, ptrap);
         else passed++;
         total++; if (retire_cnt !== exp_cnt) $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, retire_cnt, exp_cnt); else passed++;
         if (ev) begin
            total++; if (instr_pc !== exp_pc || instr_out !== mem(exp_pc))
               $display("FAIL rnd_word cyc=%0d pc=%h out=%h exp %h %h", i, instr_pc, instr_out, exp_pc, mem(exp_pc));
            else passed++;
         end else begin
            total++; if (imem_addr !== exp_pc) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, imem_addr, exp_pc); else passed++;
         end
         rd = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 11))
            0:       {jp, br, z} = 3'b100;
            1:       {jp, br, z} = 3'b011;
            2:       {jp, br, z} = 3'b010;
            3:       {jp, br, z} = 3'b111;
            4:       {jp, br, z} = 3'b001;
            default: {jp, br, z} = 3'b000;
         endcase
         jt = $urandom;
         ex = $urandom;
         imm = {$urandom, $urandom};
         ack = imem_req && (c >= dly);
         instr_ready = rd;
         jump = jp;
         branch = br;
         ALU_zero = z;
         jump_target = jt;
         ex_pc = ex;
         imm_gen_out = imm;
         imem_rdata = mem(imem_addr);
         imem_ack = ack;
         redir = jp || (br && z);
         raw = jp ? jt : ex + (imm[31:0] << 1);
         raw[0] = 1'b0;
         if (TRAP) begin
            tr = raw[1];
            t = tr ? 32'h100 : raw;
         end else begin
            tr = 1'b0;
            t = {raw[31:2], 2'b00};
         end
         if (ev && rd) exp_cnt = exp_cnt + 32'd1;
         if (redir) exp_pc = t;
         else if (ev && rd) exp_pc = exp_pc + 32'd4;
         pgood = ack && !redir && !taint;
         if (ack) begin
            taint = 1'b0;
            dly = $urandom_range(1, 3);
         end else if (redir && imem_req && c > 0) begin
            taint = 1'b1;
         end
         if (ack || redir || !imem_req) c = 0;
         else c++;
         pv = ev;
         prdy = rd;
         pred = redir;
         ptrap = redir && tr;
         @(negedge clk);
      end
      {jump, branch, ALU_zero, imem_ack} = 4'b0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_delayed_ack();
      test_branch();
      test_redirect_wait();
      test_jump_wrap();
      test_misalign();
      test_reset_midfetch();
      test_random(600);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
